// File: rtl/periph_bus_ctrl_pkg.sv
// Shared constants for the peripheral bus controller: register offsets,
// TCON bit positions and display reset patterns.
package periph_bus_ctrl_pkg;

    localparam logic [31:0] OFF_TH      = 32'h00;
    localparam logic [31:0] OFF_TL      = 32'h04;
    localparam logic [31:0] OFF_TCON    = 32'h08;
    localparam logic [31:0] OFF_LED     = 32'h0C;
    localparam logic [31:0] OFF_DIGITS  = 32'h10;
    localparam logic [31:0] OFF_SYSTICK = 32'h14;
    localparam logic [31:0] WIN_SIZE    = 32'h20;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    localparam logic [3:0] AN_RST  = 4'b1110;
    localparam logic [7:0] SEG_RST = 8'hC0;

    typedef enum logic [2:0] {
        REG_TH, REG_TL, REG_TCON, REG_LED, REG_DIGITS, REG_SYSTICK, REG_NONE
    } reg_sel_e;

endpackage

// File: rtl/periph_bus_ctrl_hex.sv
// Hex nibble to active-low 7-segment pattern, bit order gfedcba.
module hex_to_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Memory-mapped peripheral block: reloadable timer with irq, LEDs, SysTick
// and a 4-digit multiplexed 7-segment display.
module periph_bus_ctrl
    import periph_bus_ctrl_pkg::*;
#(
    parameter int          SCAN_DIV  = 50000,
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dev_sel,
    output logic        irq,
    output logic [7:0]  led,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [15:0] digits;
    logic [PW-1:0] pre;
    logic [1:0]  idx;
    logic [31:0] offset;
    reg_sel_e    sel;
    logic        we, tl_ovf;
    logic [3:0]  nib;
    logic [6:0]  seg7;

    // Offset compare is equivalent to full-address equality against BASE+OFF.
    assign offset  = addr - BASE_ADDR;
    assign dev_sel = (offset < WIN_SIZE);
    assign we      = mem_write && dev_sel;
    assign tl_ovf  = (tl == 32'hFFFF_FFFF);
    assign irq     = tcon[TCON_IS];

    always_comb begin
        sel = REG_NONE;
        if (dev_sel) begin
            case (offset)
                OFF_TH:      sel = REG_TH;
                OFF_TL:      sel = REG_TL;
                OFF_TCON:    sel = REG_TCON;
                OFF_LED:     sel = REG_LED;
                OFF_DIGITS:  sel = REG_DIGITS;
                OFF_SYSTICK: sel = REG_SYSTICK;
                default:     sel = REG_NONE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (mem_read && dev_sel) begin
            case (sel)
                REG_TH:      rdata = th;
                REG_TL:      rdata = tl;
                REG_TCON:    rdata = {29'h0, tcon};
                REG_LED:     rdata = {24'h0, led};
                REG_DIGITS:  rdata = {16'h0, digits};
                REG_SYSTICK: rdata = systick;
                default:     rdata = 32'h0;
            endcase
        end
    end

    assign nib = digits[{idx, 2'b00} +: 4];

    hex_to_seg u_hex (
        .nib (nib),
        .seg (seg7)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            led     <= '0;
            digits  <= '0;
            systick <= '0;
            pre     <= '0;
            idx     <= '0;
            an      <= AN_RST;
            seg     <= SEG_RST;
        end else begin
            systick <= systick + 32'd1;

            if (we && sel == REG_TH)     th     <= wdata;
            if (we && sel == REG_LED)    led    <= wdata[7:0];
            if (we && sel == REG_DIGITS) digits <= wdata[15:0];

            // A CPU write to TL/TCON overrides the count/reload for that register;
            // reload always takes the pre-edge TH.
            if (we && sel == REG_TL)
                tl <= wdata;
            else if (tcon[TCON_EN])
                tl <= tl_ovf ? th : tl + 32'd1;

            if (we && sel == REG_TCON)
                tcon <= wdata[2:0];
            else if (tcon[TCON_EN] && tl_ovf)
                tcon[TCON_IS] <= tcon[TCON_IS] | tcon[TCON_IE];

            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= idx + 2'd1;
            end else begin
                pre <= pre + 1'b1;
            end

            an  <= ~(4'b0001 << idx);
            seg <= {1'b1, seg7};
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Scoreboard bench for periph_bus_ctrl: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_periph_bus_ctrl;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIG  = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    typedef enum int {K_RDATA, K_DEVSEL, K_IRQ, K_AN, K_SEG, K_LED} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    logic        clk, reset_n, mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        dev_sel, irq;
    logic [7:0]  led, seg;
    logic [3:0]  an;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ticks;

    periph_bus_ctrl #(.SCAN_DIV(4), .BASE_ADDR(32'h4000_0000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .dev_sel   (dev_sel),
        .irq       (irq),
        .led       (led),
        .an        (an),
        .seg       (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference count of rising edges since reset release (expected SYSTICK).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ticks <= '0;
        else          ticks <= ticks + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, got no end of stimulus, need finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                K_RDATA:  act = rdata;
                K_DEVSEL: act = {31'h0, dev_sel};
                K_IRQ:    act = {31'h0, irq};
                K_AN:     act = {28'h0, an};
                K_SEG:    act = {24'h0, seg};
                default:  act = {24'h0, led};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got %h, expected %h", e.kind.name(), $time, act, e.exp);
            end
        end
    end

    function automatic void push_exp(input kind_e k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        addr = a; mem_read = 1'b1;
        push_exp(K_RDATA, e);
        step();
        mem_read = 1'b0;
    endtask

    // Reset asserted 3 ns after an edge and held 3 ns; checks land mid-pulse.
    task automatic reset_pulse();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        addr = A_TL; mem_read = 1'b1;
        push_exp(K_RDATA, 32'h0);
        push_exp(K_IRQ, 32'h0);
        push_exp(K_AN, 32'hE);
        push_exp(K_SEG, 32'hC0);
        #3;
        reset_n = 1'b1;
        mem_read = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] seg_tab [4];
        logic [3:0] an_exp;
        int         i;
        seg_tab = '{8'h8E, 8'h86, 8'h86, 8'h83};

        reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0;
        push_exp(K_AN, 32'hE);
        push_exp(K_SEG, 32'hC0);
        push_exp(K_RDATA, 32'h0);
        push_exp(K_IRQ, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Get timer, irq and scan busy, then reset mid-operation.
        wr(A_DIG, 32'h5555);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        step();
        step();
        push_exp(K_IRQ, 32'h1);
        repeat (5) step();
        push_exp(K_SEG, 32'h92);
        reset_pulse();
        rd(A_TL, 32'h0);
        rd(A_TCON, 32'h0);

        // Timer reload and sticky irq.
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h3);
        rd(A_TL, 32'hFFFF_FFFD);
        rd(A_TL, 32'hFFFF_FFFE);
        push_exp(K_IRQ, 32'h0);
        rd(A_TL, 32'hFFFF_FFFF);
        push_exp(K_IRQ, 32'h1);
        rd(A_TL, 32'hFFFF_FFFD);
        push_exp(K_IRQ, 32'h1);
        wr(A_TCON, 32'h3);
        push_exp(K_IRQ, 32'h0);
        wr(A_TCON, 32'h0);

        // Write to TL on the reload edge wins; irq still set.
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        step();
        wr(A_TL, 32'h10);
        push_exp(K_IRQ, 32'h1);
        rd(A_TL, 32'h10);
        wr(A_TCON, 32'h0);

        // Write to TH on the reload edge: old TH is loaded.
        wr(A_TH, 32'h7);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h1);
        step();
        wr(A_TH, 32'h5);
        push_exp(K_IRQ, 32'h0);
        rd(A_TL, 32'h7);
        wr(A_TCON, 32'h0);
        rd(A_TH, 32'h5);
        wr(A_TCON, 32'hFFFF_FFFA);
        rd(A_TCON, 32'h2);
        wr(A_TCON, 32'h0);

        // Plain register access and reserved/no-read cases.
        wr(A_LED, 32'hA5);
        wr(A_DIG, 32'h1234);
        push_exp(K_LED, 32'hA5);
        rd(A_LED, 32'hA5);
        rd(A_DIG, 32'h1234);
        wr(A_TICK, 32'hFFFF);
        rd(A_TICK, ticks);
        wr(32'h4000_0018, 32'hDEAD);
        rd(32'h4000_0018, 32'h0);
        rd(32'h4000_001C, 32'h0);
        addr = A_LED; mem_read = 1'b0;
        push_exp(K_RDATA, 32'h0);
        step();

        // Address decode boundaries.
        addr = 32'h3FFF_FFFC; push_exp(K_DEVSEL, 32'h0); step();
        addr = 32'h4000_0020; push_exp(K_DEVSEL, 32'h0); step();
        addr = 32'h4000_0014; push_exp(K_DEVSEL, 32'h1); step();
        addr = 32'h4000_001C; push_exp(K_DEVSEL, 32'h1); step();
        wr(32'h3FFF_FFFC, 32'hFF);
        wr(32'h4000_0020, 32'hFF);
        wr(32'h4000_002C, 32'h11);
        rd(A_LED, 32'hA5);

        // Display scan from a fresh reset with DIGITS=BEEF.
        reset_pulse();
        wr(A_DIG, 32'hBEEF);
        step();
        for (int k = 0; k < 20; k++) begin
            i = int'(((ticks - 32'd1) / 32'd4) % 32'd4);
            an_exp = ~(4'b0001 << i);
            push_exp(K_AN, {28'h0, an_exp});
            push_exp(K_SEG, {24'h0, seg_tab[i]});
            step();
        end

        step();
        step();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
